// File: rtl/ps2_keyboard_rx_if.sv
// PS/2 receiver bus: raw keyboard pins in, decoded scan-code pair and status pulses out.
interface ps2_keyboard_rx_if;
  logic        ps2_clk;
  logic        ps2_data;
  logic [15:0] char;
  logic        newchar;
  logic        parity_err;
  logic        frame_err;

  // The keyboard/host side drives the pins and consumes the decoded bytes.
  modport master (
    output ps2_clk, ps2_data,
    input  char, newchar, parity_err, frame_err
  );

  modport slave (
    input  ps2_clk, ps2_data,
    output char, newchar, parity_err, frame_err
  );
endinterface

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: synchronizes and deglitches the pins, deserializes 11-bit
// frames, and shifts each good scan code into a two-byte history with status pulses.
module ps2_keyboard_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input logic             clk,
  input logic             reset,
  ps2_keyboard_rx_if.slave bus
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt, fall;
  logic [FW-1:0] flt_cnt;

  state_t        state;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity_bit;
  logic [TW-1:0] to_cnt;
  logic [15:0]   char_q;
  logic          newchar_q, parity_err_q, frame_err_q;

  // Filtered level only moves after FILTER_LEN consecutive disagreeing samples;
  // fall is registered so data_sync[1] is sampled in the cycle fall is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
      clk_filt  <= 1'b1;
      flt_cnt   <= '0;
      fall      <= 1'b0;
    end else begin
      // NOTE: non-blocking everywhere in clocked logic so every flop samples pre-edge values.
      clk_sync  <= {clk_sync[0], bus.ps2_clk};
      data_sync <= {data_sync[0], bus.ps2_data};
      fall      <= 1'b0;
      if (clk_sync[1] != clk_filt) begin
        if (flt_cnt == FW'(FILTER_LEN - 1)) begin
          clk_filt <= clk_sync[1];
          flt_cnt  <= '0;
          fall     <= clk_filt;
        end else begin
          flt_cnt <= flt_cnt + 1'b1;
        end
      end else begin
        flt_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shreg        <= '0;
      parity_bit   <= 1'b0;
      to_cnt       <= '0;
      char_q       <= '0;
      newchar_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      newchar_q    <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      // A stalled partial frame is abandoned; a coincident falling edge is dropped.
      if (state != IDLE && to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
        state       <= IDLE;
        to_cnt      <= '0;
        frame_err_q <= 1'b1;
      end else begin
        if (fall || state == IDLE) to_cnt <= '0;
        else                       to_cnt <= to_cnt + 1'b1;
        if (fall) begin
          unique case (state)
            IDLE: begin
              if (!data_sync[1]) begin
                state   <= DATA;
                bit_cnt <= '0;
              end
            end
            DATA: begin
              shreg   <= {data_sync[1], shreg[7:1]};
              bit_cnt <= bit_cnt + 1'b1;
              if (bit_cnt == 3'd7) state <= PARITY;
            end
            PARITY: begin
              parity_bit <= data_sync[1];
              state      <= STOP;
            end
            STOP: begin
              if (!data_sync[1]) begin
                frame_err_q <= 1'b1;
              end else if (^{shreg, parity_bit}) begin
                char_q    <= {char_q[7:0], shreg};
                newchar_q <= 1'b1;
              end else begin
                parity_err_q <= 1'b1;
              end
              state <= IDLE;
            end
            default: state <= IDLE;
          endcase
        end
      end
    end
  end

  assign bus.char       = char_q;
  assign bus.newchar    = newchar_q;
  assign bus.parity_err = parity_err_q;
  assign bus.frame_err  = frame_err_q;
endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Self-checking bench for ps2_keyboard_rx: directed keyboard scenarios plus random
// frames, scored against a frame-level model of scan-code decoding.
module tb_ps2_keyboard_rx;
  localparam int FILTER_LEN     = 8;
  localparam int TIMEOUT_CYCLES = 2000;
  localparam int HALF           = 60;

  logic clk = 1'b0;
  logic reset;
  ps2_keyboard_rx_if bus ();

  ps2_keyboard_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_nc = 0, n_pe = 0, n_fe = 0;
  int fe_cyc = 0;
  int last_fall_cyc = 0;
  logic [15:0] model_char = 16'h0;
  logic p_nc = 1'b0, p_pe = 1'b0, p_fe = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: exclusivity, single-cycle width, latency of newchar.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.newchar | bus.parity_err | bus.frame_err)
        check("pulse_onehot", $countones({bus.newchar, bus.parity_err, bus.frame_err}), 1);
      if (p_nc | p_pe | p_fe)
        check("pulse_width", {29'd0, bus.newchar & p_nc, bus.parity_err & p_pe, bus.frame_err & p_fe}, 0);
      if (bus.newchar) begin
        n_nc++;
        check("newchar_latency", cyc - last_fall_cyc, FILTER_LEN + 3);
      end
      if (bus.parity_err) n_pe++;
      if (bus.frame_err) begin
        n_fe++;
        fe_cyc = cyc;
      end
    end
    p_nc <= bus.newchar;
    p_pe <= bus.parity_err;
    p_fe <= bus.frame_err;
  end

  function automatic logic good_par(input logic [7:0] b);
    return ~^b;
  endfunction

  // Clock out bits LSB first; optional 5-cycle low glitches in IDLE and mid-DATA.
  task automatic send_bits(input logic [10:0] bits, input int nbits, input bit glitch);
    if (glitch) begin
      @(negedge clk) bus.ps2_clk = 1'b0;
      repeat (5) @(negedge clk);
      bus.ps2_clk = 1'b1;
      repeat (30) @(negedge clk);
    end
    for (int i = 0; i < nbits; i++) begin
      @(negedge clk) bus.ps2_data = bits[i];
      if (glitch && i == 4) begin
        repeat (20) @(negedge clk);
        bus.ps2_clk = 1'b0;
        repeat (5) @(negedge clk);
        bus.ps2_clk = 1'b1;
        repeat (HALF - 25) @(negedge clk);
      end else begin
        repeat (HALF) @(negedge clk);
      end
      bus.ps2_clk   = 1'b0;
      last_fall_cyc = cyc;
      repeat (HALF) @(negedge clk);
      bus.ps2_clk = 1'b1;
    end
    @(negedge clk) bus.ps2_data = 1'b1;
  endtask

  task automatic run_frame(input logic [7:0] b, input logic par, input logic stop, input bit glitch);
    int nc0 = n_nc;
    int pe0 = n_pe;
    int fe0 = n_fe;
    int exp_nc = 0, exp_pe = 0, exp_fe = 0;
    if (!stop) exp_fe = 1;
    else if (^{b, par}) begin
      exp_nc     = 1;
      model_char = {model_char[7:0], b};
    end else exp_pe = 1;
    send_bits({stop, par, b, 1'b0}, 11, glitch);
    repeat (20) @(negedge clk);
    check("newchar_count", n_nc - nc0, exp_nc);
    check("parity_err_count", n_pe - pe0, exp_pe);
    check("frame_err_count", n_fe - fe0, exp_fe);
    check("char", bus.char, model_char);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int fe0;
    bit seen;
    logic [7:0] b;
    int kind;
    reset        = 1'b1;
    bus.ps2_clk  = 1'b1;
    bus.ps2_data = 1'b1;
    repeat (4) @(negedge clk);
    check("reset_char", bus.char, 16'h0);
    check("reset_pulses", {bus.newchar, bus.parity_err, bus.frame_err}, 3'b000);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Key make, then break sequence.
    run_frame(8'h1C, 1'b0, 1'b1, 1'b0);
    check("make_char", bus.char, 16'h001C);
    run_frame(8'hF0, 1'b1, 1'b1, 1'b0);
    check("break_prefix", bus.char, 16'h1CF0);
    run_frame(8'h1C, good_par(8'h1C), 1'b1, 1'b0);
    check("break_char", bus.char, 16'hF01C);

    // Parity fault, then a good frame.
    run_frame(8'h1C, 1'b1, 1'b1, 1'b0);
    run_frame(8'h2B, good_par(8'h2B), 1'b1, 1'b0);
    check("after_parity_fault", bus.char, 16'h1C2B);

    // Stop-bit fault.
    run_frame(8'h1C, good_par(8'h1C), 1'b0, 1'b0);

    // Partial frame, then timeout.
    fe0 = n_fe;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 4, 1'b0);
    seen = 1'b0;
    for (int i = 0; i < TIMEOUT_CYCLES + 200 && !seen; i++) begin
      @(negedge clk);
      if (n_fe != fe0) seen = 1'b1;
    end
    check("timeout_seen", seen, 1'b1);
    check("timeout_latency", fe_cyc - last_fall_cyc, FILTER_LEN + 3 + TIMEOUT_CYCLES);
    repeat (5) @(negedge clk);
    check("timeout_single", n_fe - fe0, 1);
    run_frame(8'h32, good_par(8'h32), 1'b1, 1'b0);

    // Glitches in IDLE and mid-DATA are filtered out.
    run_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b1);

    // Reset after the third data bit.
    send_bits({1'b1, 1'b0, 8'h45, 1'b0}, 4, 1'b0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    check("midreset_char", bus.char, 16'h0);
    check("midreset_pulses", {bus.newchar, bus.parity_err, bus.frame_err}, 3'b000);
    reset      = 1'b0;
    model_char = 16'h0;
    fe0        = n_fe;
    run_frame(8'h45, good_par(8'h45), 1'b1, 1'b0);
    check("post_reset_char", bus.char, 16'h0045);
    check("post_reset_no_ferr", n_fe - fe0, 0);

    // Random frames with random fault injection.
    for (int k = 0; k < 14; k++) begin
      b    = 8'($urandom);
      kind = int'($urandom_range(0, 3));
      run_frame(b, (kind == 2) ? ^b : ~^b, kind != 3, $urandom_range(0, 3) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
